// File: rtl/wave_gen_poly.sv
// Multi-voice phase-accumulator wave generator.
// Sums NUM_VOICES oscillators (off/saw/square/triangle, per-voice step and
// gain) into one saturated signed sample per req_next, one voice per clock.
// Optional build macro: WAVE_GEN_PHASE_SYNC_EN adds voice_phase_clr, which
// zeroes the selected voice's phase on a configuration write.
module wave_gen_poly #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 req_next,
  input  logic                                                 voice_we,
  input  logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] voice_sel,
  input  logic [PHASE_W-1:0]                                   voice_step,
  input  logic [1:0]                                           voice_mode,
  input  logic [7:0]                                           voice_gain,
`ifdef WAVE_GEN_PHASE_SYNC_EN
  input  logic                                                 voice_phase_clr,
`endif
  output logic [DATA_W-1:0]                                    aud_data,
  output logic                                                 aud_done
);

  localparam int unsigned SEL_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned ACC_W  = DATA_W + 1 + $clog2(NUM_VOICES) + 1;
  // signed shape (DATA_W) times zero-extended gain (9 bits)
  localparam int unsigned PROD_W = DATA_W + 9;
  localparam int unsigned M_INT  = (2 ** (DATA_W - 1)) - 1;

  localparam logic [DATA_W-1:0]       S_POS   = DATA_W'(M_INT);
  localparam logic [DATA_W-1:0]       S_NEG   = ~S_POS + DATA_W'(1);
  localparam logic [DATA_W-1:0]       S_MIN   = ~S_POS;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(M_INT);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_TRI    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t                   state;
  logic [SEL_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;

  logic [PHASE_W-1:0]       phase [NUM_VOICES];
  logic [PHASE_W-1:0]       step  [NUM_VOICES];
  logic [1:0]               mode  [NUM_VOICES];
  logic [7:0]               gain  [NUM_VOICES];

  logic [DATA_W-1:0]        cur_t_c;
  logic [1:0]               cur_mode_c;
  logic [7:0]               cur_gain_c;
  logic [DATA_W-2:0]        tri_u_c;
  logic [DATA_W-1:0]        tri_c;
  logic [DATA_W-1:0]        shape_c;
  logic signed [PROD_W-1:0] shape_w_c;
  logic signed [PROD_W-1:0] gain_w_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  contrib_c;
  logic [DATA_W-1:0]        sat_c;
  logic                     phase_clr_c;

`ifdef WAVE_GEN_PHASE_SYNC_EN
  assign phase_clr_c = voice_phase_clr;
`else
  assign phase_clr_c = 1'b0;
`endif

  // Select the top phase bits, mode and gain of the voice being processed.
  always_comb begin
    cur_t_c    = '0;
    cur_mode_c = MODE_OFF;
    cur_gain_c = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (idx == SEL_W'(v)) begin
        cur_t_c    = phase[v][PHASE_W-1 -: DATA_W];
        cur_mode_c = mode[v];
        cur_gain_c = gain[v];
      end
    end
  end

  // Waveform shaping and gain scaling of the current voice.
  always_comb begin
    tri_u_c = cur_t_c[DATA_W-1] ? ~cur_t_c[DATA_W-2:0] : cur_t_c[DATA_W-2:0];
    // 2u - M always fits DATA_W signed, so modular subtraction is exact
    tri_c   = {tri_u_c, 1'b0} - S_POS;
    case (cur_mode_c)
      MODE_SAW:    shape_c = {~cur_t_c[DATA_W-1], cur_t_c[DATA_W-2:0]};
      MODE_SQUARE: shape_c = cur_t_c[DATA_W-1] ? S_NEG : S_POS;
      MODE_TRI:    shape_c = tri_c;
      default:     shape_c = '0;
    endcase
    shape_w_c = PROD_W'($signed(shape_c));
    gain_w_c  = PROD_W'({1'b0, cur_gain_c});
    prod_c    = shape_w_c * gain_w_c;
    // arithmetic shift floors toward -inf; result fits ACC_W
    contrib_c = ACC_W'(prod_c >>> 7);
  end

  // Clamp the accumulated mix to the signed output range.
  always_comb begin
    if (acc > ACC_MAX) begin
      sat_c = S_POS;
    end else if (acc < ACC_MIN) begin
      sat_c = S_MIN;
    end else begin
      sat_c = acc[DATA_W-1:0];
    end
  end

  // Request sequencing: IDLE -> one ACCUM cycle per voice -> OUTPUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      acc      <= '0;
      aud_data <= '0;
      aud_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_next) begin
            aud_done <= 1'b0;
            acc      <= '0;
            idx      <= '0;
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc <= acc + contrib_c;
          if (idx == SEL_W'(NUM_VOICES - 1)) begin
            state <= ST_OUTPUT;
          end else begin
            idx <= idx + SEL_W'(1);
          end
        end
        ST_OUTPUT: begin
          aud_data <= sat_c;
          aud_done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Voice registers: configuration writes and per-sample phase advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        step[v]  <= '0;
        mode[v]  <= MODE_OFF;
        gain[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_we && (voice_sel == SEL_W'(v))) begin
          step[v] <= voice_step;
          mode[v] <= voice_mode;
          gain[v] <= voice_gain;
        end
        // phase clear wins over a same-cycle advance; advance uses old step
        if (voice_we && phase_clr_c && (voice_sel == SEL_W'(v))) begin
          phase[v] <= '0;
        end else if ((state == ST_ACCUM) && (idx == SEL_W'(v)) &&
                     (mode[v] != MODE_OFF)) begin
          phase[v] <= phase[v] + step[v];
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_gen_poly.sv
// Randomised scoreboard bench for wave_gen_poly (default parameters).
module tb_wave_gen_poly;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_next;
  logic        voice_we;
  logic [1:0]  voice_sel;
  logic [31:0] voice_step;
  logic [1:0]  voice_mode;
  logic [7:0]  voice_gain;
`ifdef WAVE_GEN_PHASE_SYNC_EN
  logic        voice_phase_clr;
`endif
  logic [15:0] aud_data;
  logic        aud_done;

  wave_gen_poly dut (
    .clk        (clk),
    .reset      (reset),
    .req_next   (req_next),
    .voice_we   (voice_we),
    .voice_sel  (voice_sel),
    .voice_step (voice_step),
    .voice_mode (voice_mode),
    .voice_gain (voice_gain),
`ifdef WAVE_GEN_PHASE_SYNC_EN
    .voice_phase_clr (voice_phase_clr),
`endif
    .aud_data   (aud_data),
    .aud_done   (aud_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          req_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  // reference model state
  logic [31:0] m_phase [NV];
  logic [31:0] m_step  [NV];
  int          m_mode  [NV];
  int          m_gain  [NV];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int voice_contrib(logic [31:0] ph, int md, int g);
    int t;
    int s;
    int u;
    t = int'(ph[31:16]);
    case (md)
      1: s = t - 32768;
      2: s = (t < 32768) ? 32767 : -32767;
      3: begin
        u = (t < 32768) ? t : 65535 - t;
        s = 2 * u - 32767;
      end
      default: s = 0;
    endcase
    return (s * g) >>> 7;
  endfunction

  function automatic logic [15:0] model_sample();
    int sum = 0;
    for (int v = 0; v < NV; v++) sum += voice_contrib(m_phase[v], m_mode[v], m_gain[v]);
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return 16'(sum);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0;
      m_step[v]  = '0;
      m_mode[v]  = 0;
      m_gain[v]  = 0;
    end
  endtask

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising aud_done is one completed sample.
  always @(negedge clk) begin
    exp_t e;
    if (reset && aud_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got data %0h, expected no completion", aud_data);
      end else begin
        e = exp_q.pop_front();
        check("aud_data", int'(aud_data), int'(e.data));
        check("latency", cyc - e.req_cyc, NV + 1);
      end
    end
    done_prev = aud_done;
  end

  task automatic write_voice(int sel, logic [31:0] st, int md, int g, bit clr);
    @(negedge clk);
    voice_we   = 1'b1;
    voice_sel  = 2'(sel);
    voice_step = st;
    voice_mode = 2'(md);
    voice_gain = 8'(g);
`ifdef WAVE_GEN_PHASE_SYNC_EN
    voice_phase_clr = clr;
`endif
    @(posedge clk);
    if (sel < NV) begin
      m_step[sel] = st;
      m_mode[sel] = md;
      m_gain[sel] = g;
`ifdef WAVE_GEN_PHASE_SYNC_EN
      if (clr) m_phase[sel] = '0;
`else
      if (clr) m_phase[sel] = m_phase[sel];
`endif
    end
    #1;
    voice_we = 1'b0;
`ifdef WAVE_GEN_PHASE_SYNC_EN
    voice_phase_clr = 1'b0;
`endif
  endtask

  // Issue a request; push its expected sample and advance the model phases.
  task automatic issue_req();
    exp_t e;
    @(negedge clk);
    req_next = 1'b1;
    e.req_cyc = cyc + 1;
    e.data = model_sample();
    exp_q.push_back(e);
    for (int v = 0; v < NV; v++) if (m_mode[v] != 0) m_phase[v] += m_step[v];
    @(posedge clk);
    #1;
    req_next = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d samples outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("reset_aud_done", int'(aud_done), 0);
    check("reset_aud_data", int'(aud_data), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    req_next   = 1'b0;
    voice_we   = 1'b0;
    voice_sel  = '0;
    voice_step = '0;
    voice_mode = '0;
    voice_gain = '0;
`ifdef WAVE_GEN_PHASE_SYNC_EN
    voice_phase_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // single saw voice: 0x8000, 0x9000, ... wraps back to 0x8000 on request 17
    write_voice(0, 32'h1000_0000, 1, 128, 1'b0);
    for (int i = 0; i < 17; i++) begin
      issue_req();
      wait_idle();
    end

    // gain 64 saw and unity triangle at phase 0
    do_reset();
    write_voice(0, 32'h0, 1, 64, 1'b0);
    issue_req();
    wait_idle();
    do_reset();
    write_voice(0, 32'h0, 3, 128, 1'b0);
    issue_req();
    wait_idle();

    // saturation, positive then negative
    do_reset();
    write_voice(0, 32'h0, 2, 128, 1'b0);
    write_voice(1, 32'h0, 2, 128, 1'b0);
    issue_req();
    wait_idle();
    write_voice(0, 32'h8000_0000, 2, 255, 1'b0);
    write_voice(1, 32'h8000_0000, 2, 255, 1'b0);
    issue_req();
    wait_idle();
    issue_req();
    wait_idle();

    // req_next while busy is ignored; phase advances once
    do_reset();
    write_voice(0, 32'h1000_0000, 1, 128, 1'b0);
    issue_req();
    @(negedge clk);
    @(negedge clk);
    req_next = 1'b1;
    @(posedge clk);
    #1;
    req_next = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    issue_req();
    wait_idle();

    // write to voice1 in the cycle it is being mixed
    do_reset();
    write_voice(1, 32'h0, 1, 128, 1'b0);
    issue_req();
    @(negedge clk);
    write_voice(1, 32'h0, 1, 64, 1'b0);
    wait_idle();
    issue_req();
    wait_idle();

    // randomised configuration and requests
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        write_voice($urandom_range(0, NV - 1), $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
      end
      issue_req();
      wait_idle();
    end

    // reset in the middle of a computation
    issue_req();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_aud_done", int'(aud_done), 0);
    check("midreset_aud_data", int'(aud_data), 0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue_req();
    wait_idle();

    // phase alignment on note-on
    do_reset();
    write_voice(0, 32'h1000_0000, 1, 128, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue_req();
      wait_idle();
    end
    write_voice(0, 32'h1000_0000, 1, 128, 1'b1);
    issue_req();
    wait_idle();

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wave_gen_poly.md
Name: wave_gen_poly

Overview:
- Multi-voice successor to the single-voice audio wave generator.
- Sums NUM_VOICES independent fixed-point phase-accumulator oscillators, each with its own waveform mode, step and gain, into one saturated signed sample per request.
- Sits between the voice-control register interface and the audio codec sample path.
- Uses the same req_next / aud_data / aud_done handshake as the existing generator.

Parameters:
- NUM_VOICES, 4: number of oscillators (>=1).
- PHASE_W, 32: phase accumulator and step width.
- DATA_W, 16: output sample width, signed two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_next  in  1  single-cycle request for the next sample.
- voice_we  in  1  voice configuration write strobe.
- voice_sel  in  $clog2(NUM_VOICES) (min 1)  voice index for the write.
- voice_step  in  PHASE_W  phase increment per sample.
- voice_mode  in  2  waveform: 0 off, 1 saw, 2 square, 3 triangle.
- voice_gain  in  8  unsigned gain, 128 = unity (range 0..~1.99).
- aud_data  out  DATA_W  mixed sample.
- aud_done  out  1  level; high while aud_data holds a fresh sample.

Behaviour:
- Reset (reset=0, asynchronous):
  - all phases, steps, gains and the accumulator go to 0; all modes go to off.
  - FSM goes to IDLE; aud_data=0; aud_done=0.
  - Reset mid-computation aborts the computation; no partial sample is ever output.
- Configuration:
  - Each voice has step/mode/gain registers, written on the clk edge where voice_we=1.
  - Writes with voice_sel >= NUM_VOICES are ignored.
  - A write to the voice being processed in that same cycle: the old values are used for this sample; the new values apply from the next sample.
  - Writes are accepted in any state.
- FSM IDLE:
  - Edge E0 with req_next=1: aud_done<=0, acc<=0, idx<=0, go to ACCUM.
  - req_next while not in IDLE is ignored.
- FSM ACCUM, edges E1..EN (one voice per cycle, voice idx):
  - t = phase[PHASE_W-1 -: DATA_W], unsigned. M = 2^(DATA_W-1)-1.
  - saw: s = t with MSB inverted, read as signed.
  - square: s = +M if t MSB=0, else -M.
  - triangle: u = t MSB ? ~t[DATA_W-2:0] : t[DATA_W-2:0]; s = 2u - M.
  - off: s = 0 and the phase is held.
  - contribution = (s * gain) >>> 7, arithmetic shift, truncated toward -inf.
  - acc (width DATA_W+1+$clog2(NUM_VOICES)+1) += contribution.
  - The sample uses the current phase. Afterwards, for non-off voices, phase <= phase + step modulo 2^PHASE_W (wraps silently).
  - At idx=NUM_VOICES-1, go to OUTPUT.
- FSM OUTPUT, edge E(N+1):
  - aud_data <= acc saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; aud_done<=1; go to IDLE.
  - Latency: aud_done is high after NUM_VOICES+1 clocks following the request edge.
  - aud_data and aud_done hold until the next accepted req_next.

Optional Feature:
- Macro: WAVE_GEN_PHASE_SYNC_EN.
- Defined:
  - adds input port voice_phase_clr (1 bit).
  - A write with voice_we=1 and voice_phase_clr=1 also zeroes the selected voice's phase; this overrides the advance if that voice is processed in the same cycle.
  - Used for note-on phase alignment.
- Undefined: no port; phases only ever advance from reset.

Test Plan:
- Single voice:
  - Setup: reset; voice0 saw, step 32'h10000000, gain 128; others off.
  - Request 1 -> aud_data=16'h8000, with aud_done rising exactly 5 clocks after the req edge (NUM_VOICES=4).
  - Request 2 -> 16'h9000.
  - Request 17 -> 16'h8000 (phase wrap).
- Gain and triangle:
  - voice0 saw, phase 0, gain 64 -> 16'hC000.
  - voice0 triangle, phase 0, gain 128 -> 16'h8001.
- Saturation:
  - voices 0 and 1 square, step 0, gain 128 -> sum 65534 clamps to 16'h7FFF.
  - same voices with gain 255 and step 32'h80000000, second request -> clamps to 16'h8000.
- Handshake:
  - req_next pulsed again 2 clocks after a request -> ignored; exactly one completion, aud_done stays low until then, phase advanced once.
  - Config write to voice1 during its ACCUM cycle -> old gain used now, new gain on the next sample.
- Reset mid-operation:
  - reset asserted at E2 -> aud_done=0 and aud_data=0 immediately.
  - After release, a request with all voices off -> 16'h0000.
- WAVE_GEN_PHASE_SYNC_EN:
  - saw voice advanced 3 requests with step 32'h10000000, then written with voice_phase_clr=1 -> next sample 16'h8000.
  - With the macro undefined -> next sample 16'hB000.
